// File: rtl/alu_serial.sv
// alu_serial: bit-serial WIDTH-bit ALU, LSB first through one registered carry, valid/ready on both sides
module alu_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic [2:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh, res_nx;
  logic [WIDTH-2:0] res_sh;
  logic [2:0] op;
  logic carry, carry_nx, last, arith, bb, bit_r;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) :
               (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready  = state == IDLE && !rst;
    out_valid = state == DONE;
  end
  // SUB reuses the adder with inverted B and the carry preset to 1
  always_comb begin
    last     = cnt == CW'(WIDTH - 1);
    arith    = op[2] & ~op[1];
    bb       = op[0] ? ~b_sh[0] : b_sh[0];
    carry_nx = (a_sh[0] & bb) | (carry & (a_sh[0] ^ bb));
    bit_r    = arith ? a_sh[0] ^ bb ^ carry :
               op[2] ? (op[0] ? b_sh[0] : a_sh[0]) :
               op[1] ? (op[0] ? ~(a_sh[0] | b_sh[0]) : a_sh[0] ^ b_sh[0]) :
               (op[0] ? a_sh[0] | b_sh[0] : a_sh[0] & b_sh[0]);
    res_nx   = {bit_r, res_sh};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      carry     <= 1'b0;
      out       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (in_valid && in_ready) begin
      a_sh  <= a;
      b_sh  <= b;
      op    <= select;
      carry <= select == 3'b100 ? carry_in : select == 3'b101;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nx[WIDTH-1:1];
      carry  <= carry_nx;
      cnt    <= cnt + 1'b1;
      if (last) begin
        out       <= res_nx;
        carry_out <= arith & carry_nx;
        overflow  <= arith & (carry ^ carry_nx);
        zero      <= ~|res_nx;
      end
    end
  end
endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: scoreboard bench for alu_serial at WIDTH=4 (directed + sweep) and WIDTH=8 (random with stalls)
module tb_alu_serial;
  typedef logic [10:0] exp_t;
  logic clk = 0, rst = 1, iv = 0, ph8 = 0, cin = 0, ordy = 1, rnd_en = 0, stall = 0;
  logic [7:0] a = 0, b = 0;
  logic [2:0] sel = 0;
  logic iv4, iv8, ir4, ir8, ov4, ov8, co4, co8, vf4, vf8, z4, z8, out_ready;
  logic [3:0] out4;
  logic [7:0] out8, ro;
  logic ir, ov, rc, rv, rz;
  exp_t q[$];
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign iv4 = iv & ~ph8;
  assign iv8 = iv & ph8;
  assign out_ready = rnd_en ? ~stall : ordy;
  assign ir = ph8 ? ir8 : ir4;
  assign ov = ph8 ? ov8 : ov4;
  assign ro = ph8 ? out8 : {4'b0, out4};
  assign rc = ph8 ? co8 : co4;
  assign rv = ph8 ? vf8 : vf4;
  assign rz = ph8 ? z8 : z4;

  alu_serial #(.WIDTH(4)) d4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a[3:0]), .b(b[3:0]),
    .carry_in(cin), .select(sel), .out_valid(ov4), .out_ready(out_ready), .out(out4),
    .carry_out(co4), .overflow(vf4), .zero(z4));

  alu_serial #(.WIDTH(8)) d8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a), .b(b),
    .carry_in(cin), .select(sel), .out_valid(ov8), .out_ready(out_ready), .out(out8),
    .carry_out(co8), .overflow(vf8), .zero(z8));

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] x, y, input logic ci, input int w);
    int m, xa, yb, r, s, c, v;
    m = (1 << w) - 1; xa = x & m; yb = y & m; c = 0; v = 0; r = 0;
    case (op)
      3'd0: r = xa & yb;
      3'd1: r = xa | yb;
      3'd2: r = xa ^ yb;
      3'd3: r = ~(xa | yb);
      3'd6: r = xa;
      3'd7: r = yb;
      default: begin
        if (op == 3'd5) yb = ~yb & m;
        s = xa + yb + (op == 3'd5 ? 1 : int'(ci));
        r = s;
        c = (s >> w) & 1;
        v = int'((((xa >> (w-1)) & 1) == ((yb >> (w-1)) & 1)) && (((s >> (w-1)) & 1) != ((xa >> (w-1)) & 1)));
      end
    endcase
    r &= m;
    return {r == 0, v[0], c[0], r[7:0]};
  endfunction

  task automatic check(input string nm, input exp_t act, input exp_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: a result leaves the DUT on every out_valid && out_ready edge
  always @(negedge clk)
    if (ov && out_ready && !rst) begin
      if (q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_result: got %h expected none", {rz, rv, rc, ro});
      end else check("result", {rz, rv, rc, ro}, q.pop_front());
    end

  always @(posedge clk) begin
    #1 stall = ($urandom_range(0, 2) == 0);
  end

  task automatic issue(input logic [2:0] op, input logic [7:0] x, y, input logic ci, input exp_t e, input bit push);
    int t = 0;
    @(negedge clk);
    while (!ir && t < 100) begin @(negedge clk); t++; end
    if (!ir) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
      return;
    end
    sel = op; a = x; b = y; cin = ci; iv = 1;
    @(posedge clk);
    if (push) q.push_back(e);
    #1 iv = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 400) begin @(negedge clk); t++; end
    check("drain_queue_empty", 11'(q.size()), 11'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    @(negedge clk) check("in_ready_during_reset", 11'(ir), 11'd0);
    @(posedge clk) #1 rst = 0;
    @(negedge clk);
    check("reset_outputs", {rz, rv, rc, ro}, 11'd0);
    check("reset_out_valid", 11'(ov), 11'd0);
    check("reset_in_ready", 11'(ir), 11'd1);

    issue(3'b100, 8'h07, 8'h01, 1'b0, {1'b0, 1'b1, 1'b0, 8'h08}, 1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ov) begin lat = i; break; end
    end
    check("latency", 11'(lat), 11'd4);
    issue(3'b101, 8'h03, 8'h03, 1'b1, {1'b1, 1'b0, 1'b1, 8'h00}, 1);
    issue(3'b101, 8'h00, 8'h01, 1'b0, {1'b0, 1'b0, 1'b0, 8'h0F}, 1);
    issue(3'b100, 8'h0F, 8'h01, 1'b1, {1'b0, 1'b0, 1'b1, 8'h01}, 1);
    issue(3'b100, 8'h08, 8'h08, 1'b0, {1'b1, 1'b1, 1'b1, 8'h00}, 1);
    drain();

    ordy = 0;
    issue(3'b100, 8'h03, 8'h04, 1'b0, {1'b0, 1'b0, 1'b0, 8'h07}, 1);
    for (int t = 0; t < 20 && !ov; t++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 iv = (i % 2 == 0); a = 8'(i + 9); b = 8'(i * 3); sel = 3'(i);
      @(negedge clk);
      check("bp_out_valid", 11'(ov), 11'd1);
      check("bp_result_held", {rz, rv, rc, ro}, {1'b0, 1'b0, 1'b0, 8'h07});
      check("bp_in_ready", 11'(ir), 11'd0);
    end
    @(posedge clk); #1 iv = 0; ordy = 1;
    drain();
    repeat (12) @(negedge clk) check("bp_no_extra_op", 11'(ov), 11'd0);

    issue(3'b010, 8'h0A, 8'h06, 1'b0, 11'd0, 0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1;
    @(negedge clk) check("midrun_rst_in_ready", 11'(ir), 11'd0);
    @(posedge clk) #1 rst = 0;
    @(negedge clk);
    check("midrun_rst_out_valid", 11'(ov), 11'd0);
    check("midrun_rst_outputs", {rz, rv, rc, ro}, 11'd0);
    check("midrun_rst_in_ready_after", 11'(ir), 11'd1);
    issue(3'b010, 8'h0A, 8'h06, 1'b0, {1'b0, 1'b0, 1'b0, 8'h0C}, 1);
    drain();

    for (int op = 0; op < 8; op++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          for (int c = 0; c < 2; c++)
            issue(3'(op), 8'(x), 8'(y), 1'(c), model(3'(op), 8'(x), 8'(y), 1'(c), 4), 1);
    drain();

    ph8 = 1; rnd_en = 1;
    for (int i = 0; i < 1000; i++) begin
      logic [2:0] op; logic [7:0] x, y; logic c;
      op = 3'($urandom_range(0, 7)); x = 8'($urandom); y = 8'($urandom); c = 1'($urandom_range(0, 1));
      issue(op, x, y, c, model(op, x, y, c, 8), 1);
    end
    drain();
    rnd_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
